// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB completer-side bundle between the bridge
// and apb_slave_mem (select, strobe, address, data, read return).
interface apb_slave_mem_if;
    logic [3:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata
    );
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer (no PREADY/PSLVERR) backed by a word
// register file, with transfer counters and a sticky protocol-error flag.
module apb_slave_mem #(
    parameter int SLAVE_ID  = 0,
    parameter int ADDR_BITS = 4
) (
    input  logic           clock,
    input  logic           Hresetn,
    apb_slave_mem_if.slave bus,
    output logic           proto_err,
    output logic [15:0]    wr_count,
    output logic [15:0]    rd_count
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t               state;
    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic                 write_q;
    logic [ADDR_BITS-1:0] idx_q;
    logic [31:0]          mem [DEPTH];

    logic own;
    logic onehot;
    logic sel;
    logic multi;
    logic same;

    always_comb begin
        own    = bus.Pselx[SLAVE_ID];
        onehot = (bus.Pselx != 4'b0) &&
                 ((bus.Pselx & (bus.Pselx - 4'd1)) == 4'b0);
        sel    = own && onehot;
        multi  = own && !onehot;
        same   = (bus.Paddr == addr_q) && (bus.Pwrite == write_q);
    end

    assign idx_q = addr_q[ADDR_BITS+1:2];

    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            bus.Prdata <= '0;
            proto_err  <= 1'b0;
            wr_count   <= '0;
            rd_count   <= '0;
        end else begin
            bus.Prdata <= '0;
            // Multi-bit select that includes us is a violation in any state
            if (multi) proto_err <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (sel && !bus.Penable) begin
                        state   <= SETUP;
                        addr_q  <= bus.Paddr;
                        write_q <= bus.Pwrite;
                        wdata_q <= bus.Pwdata;
                    end else if (sel && bus.Penable) begin
                        proto_err <= 1'b1;
                    end
                end
                SETUP: begin
                    if (sel && bus.Penable && same) begin
                        state <= ACCESS;
                        if (!write_q) bus.Prdata <= mem[idx_q];
                    end else begin
                        state     <= IDLE;
                        proto_err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (write_q) wr_count <= wr_count + 16'd1;
                    else         rd_count <= rd_count + 16'd1;
                    if (sel && !bus.Penable) begin
                        state   <= SETUP;
                        addr_q  <= bus.Paddr;
                        write_q <= bus.Pwrite;
                        wdata_q <= bus.Pwdata;
                    end else begin
                        state <= IDLE;
                        if (sel) proto_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is intentionally unreset; a reset drops state to IDLE so
    // an interrupted write never commits.
    always_ff @(posedge clock) begin
        if (state == ACCESS && write_q) mem[idx_q] <= wdata_q;
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed and randomized APB traffic against a
// word-array reference model of apb_slave_mem.
module tb_apb_slave_mem;
    logic        clock = 1'b0;
    logic        Hresetn;
    logic        proto_err;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    apb_slave_mem_if bus ();

    apb_slave_mem #(
        .SLAVE_ID (0),
        .ADDR_BITS(4)
    ) dut (
        .clock    (clock),
        .Hresetn  (Hresetn),
        .bus      (bus),
        .proto_err(proto_err),
        .wr_count (wr_count),
        .rd_count (rd_count)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ref_mem   [16];
    bit          ref_valid [16];
    int unsigned ref_wr;
    int unsigned ref_rd;
    bit          ref_err;

    bit          pend;
    bit          pend_w;
    int          pend_idx;
    logic [31:0] pend_data;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status(string tag);
        check({tag, "_proto_err"}, {31'b0, proto_err}, {31'b0, ref_err});
        check({tag, "_wr_count"}, {16'b0, wr_count}, ref_wr % 32'h10000);
        check({tag, "_rd_count"}, {16'b0, rd_count}, ref_rd % 32'h10000);
    endtask

    // One clock; a transfer whose access phase just ended completes here
    task automatic tick();
        @(posedge clock);
        #1;
        if (pend) begin
            if (pend_w) begin
                ref_mem[pend_idx]   = pend_data;
                ref_valid[pend_idx] = 1'b1;
                ref_wr++;
            end else begin
                ref_rd++;
            end
            pend = 1'b0;
        end
    endtask

    task automatic xfer(bit w, logic [31:0] addr, logic [31:0] data);
        int idx;
        idx = int'(addr[5:2]);
        bus.Pselx   = 4'b0001;
        bus.Penable = 1'b0;
        bus.Pwrite  = w;
        bus.Paddr   = addr;
        bus.Pwdata  = data;
        tick();
        check("setup_prdata", bus.Prdata, 32'h0);
        bus.Penable = 1'b1;
        bus.Pwdata  = $urandom();
        tick();
        if (w) check("wr_access_prdata", bus.Prdata, 32'h0);
        else   check("rd_access_prdata", bus.Prdata, ref_mem[idx]);
        pend      = 1'b1;
        pend_w    = w;
        pend_idx  = idx;
        pend_data = data;
    endtask

    task automatic idle(logic [3:0] psel, bit en);
        bus.Pselx   = psel;
        bus.Penable = en;
        tick();
        check("idle_prdata", bus.Prdata, 32'h0);
        check_status("idle");
    endtask

    task automatic do_reset();
        bus.Pselx   = 4'b0;
        bus.Penable = 1'b0;
        Hresetn     = 1'b0;
        pend        = 1'b0;
        ref_wr      = 0;
        ref_rd      = 0;
        ref_err     = 1'b0;
        #1;
        check("rst_prdata", bus.Prdata, 32'h0);
        check_status("rst");
        @(posedge clock);
        #1;
        Hresetn = 1'b1;
    endtask

    initial begin
        int          idx;
        bit          w;
        logic [31:0] addr;

        Hresetn     = 1'b1;
        bus.Pselx   = 4'b0;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b0;
        bus.Paddr   = 32'h0;
        bus.Pwdata  = 32'h0;
        pend        = 1'b0;
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        #2;
        do_reset();

        // Basic write then readback
        xfer(1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        idle(4'b0, 1'b0);
        xfer(1'b0, 32'h0000_0008, 32'h0);
        idle(4'b0, 1'b0);
        check("basic_wr_count", {16'b0, wr_count}, 32'd1);
        check("basic_rd_count", {16'b0, rd_count}, 32'd1);

        // Back-to-back write then read of the same word
        xfer(1'b1, 32'h0000_0004, 32'h0000_0001);
        xfer(1'b0, 32'h0000_0004, 32'h0);
        idle(4'b0, 1'b0);

        // Address aliasing: 0x44 lands on word 1
        xfer(1'b1, 32'h0000_0044, 32'hA5A5_0044);
        xfer(1'b0, 32'h0000_0004, 32'h0);
        xfer(1'b0, 32'h0000_0008, 32'h0);
        idle(4'b0, 1'b0);

        // Other slaves selected: no response, no error
        for (int k = 1; k < 4; k++) idle(4'b0001 << k, k[0]);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            idx = int'($urandom_range(15, 0));
            w   = ($urandom_range(1, 0) == 1) || !ref_valid[idx];
            addr = ($urandom() & 32'hFFFF_FFC3) | (32'(idx) << 2);
            xfer(w, addr, $urandom());
            if ($urandom_range(2, 0) == 0)
                idle(4'($urandom() & 32'hE), $urandom_range(1, 0) == 1);
        end
        idle(4'b0, 1'b0);

        // Multi-bit select including ours
        bus.Pselx   = 4'b0011;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h8;
        tick();
        ref_err = 1'b1;
        check("multi_prdata", bus.Prdata, 32'h0);
        check_status("multi");
        idle(4'b0, 1'b0);
        do_reset();

        // Penable high while idle
        bus.Pselx   = 4'b0001;
        bus.Penable = 1'b1;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h8;
        bus.Pwdata  = 32'h5555_5555;
        tick();
        ref_err = 1'b1;
        check_status("en_idle");
        idle(4'b0, 1'b0);
        xfer(1'b0, 32'h8, 32'h0);
        idle(4'b0, 1'b0);
        do_reset();

        // Address change between setup and access aborts the write
        bus.Pselx   = 4'b0001;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h8;
        bus.Pwdata  = 32'h1234_5678;
        tick();
        bus.Penable = 1'b1;
        bus.Paddr   = 32'hC;
        tick();
        ref_err = 1'b1;
        check("addr_chg_prdata", bus.Prdata, 32'h0);
        check_status("addr_chg");
        idle(4'b0, 1'b0);
        xfer(1'b0, 32'h8, 32'h0);
        idle(4'b0, 1'b0);
        idle(4'b0, 1'b0);
        do_reset();

        // Reset during the access phase of a write
        xfer(1'b1, 32'h10, 32'hCAFE_0010);
        idle(4'b0, 1'b0);
        xfer(1'b1, 32'h10, 32'h0BAD_F00D);
        do_reset();
        xfer(1'b0, 32'h10, 32'h0);
        idle(4'b0, 1'b0);
        check("rst_abort_rd_count", {16'b0, rd_count}, 32'd1);

        // Write counter wrap, preloaded near the top
        force dut.wr_count = 16'hFFFE;
        #1;
        release dut.wr_count;
        ref_wr = 32'hFFFE;
        xfer(1'b1, 32'h20, 32'h0000_0020);
        idle(4'b0, 1'b0);
        check("wrap_ffff", {16'b0, wr_count}, 32'h0000_FFFF);
        xfer(1'b1, 32'h24, 32'h0000_0024);
        idle(4'b0, 1'b0);
        check("wrap_zero", {16'b0, wr_count}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

Synthesizable APB (no PREADY/PSLVERR) completer that responds to one bit of the bridge's 4-bit Pselx bus and backs it with a small word-addressed register file. Sits on the APB side of the AHB-to-APB bridge as the peripheral that consumes Penable/Pwrite/Paddr/Pwdata and returns Prdata. It gives the bench a real responder with readback, transfer counters and a sticky protocol-violation flag.

## Interface
- SLAVE_ID, 0: index of the Pselx bit that selects this slave (0..3).
- ADDR_BITS, 4: word-index width; memory depth 2**ADDR_BITS 32-bit words.
- clock  input  1  system clock; all state updates on its rising edge.
- Hresetn  input  1  reset, asynchronous and active-low.
- Pselx  input  4  APB select bus from bridge.
- Penable  input  1  APB enable strobe.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  byte address; word index = Paddr[ADDR_BITS+1:2], other bits ignored (aliasing).
- Pwdata  input  32  write data.
- Prdata  output  32  read data, valid during ACCESS of a read, else 0.
- proto_err  output  1  sticky protocol-violation flag.
- wr_count  output  16  completed writes, wraps.
- rd_count  output  16  completed reads, wraps.

## Operation
- sel = Pselx[SLAVE_ID] && Pselx is onehot. Pselx with >1 bit set: sel = 0; if Pselx[SLAVE_ID] set, proto_err <= 1.
- FSM states IDLE, SETUP, ACCESS; sampled every rising edge:
  - IDLE: sel && !Penable -> SETUP, latch addr index, Pwrite, Pwdata. sel && Penable -> proto_err, stay IDLE. else stay.
  - SETUP: sel && Penable && Paddr, Pwrite unchanged vs latched -> ACCESS; for a read, Prdata <= mem[index] on this edge. Any other input -> proto_err, IDLE, no transfer.
  - ACCESS: transfer completes on this edge: write commits mem[index] <= latched Pwdata, wr_count++; read rd_count++. Next: sel && !Penable -> SETUP (back-to-back, relatch); !sel -> IDLE; sel && Penable -> proto_err, IDLE.
- Prdata <= 0 on every edge whose next state is not ACCESS-of-a-read; never driven during writes.
- Memory is not reset; contents after reset undefined (bench must write before read).
- Counters wrap 0xFFFF -> 0x0000 silently.
- proto_err clears only on reset.
- Write data latched in SETUP; a Pwdata change in ACCESS is ignored (not an error).

## Timing
- Reset (asynchronous, Hresetn low): state IDLE, Prdata 0, proto_err 0, wr_count 0, rd_count 0. Reset mid-transfer aborts it; no memory write, no count.
- Minimum transfer: 2 cycles (SETUP, ACCESS); zero wait states.
- Read latency: Prdata valid from the edge ending SETUP through the edge ending ACCESS; bridge samples at end of ACCESS.
- Write visible to a read whose SETUP follows immediately (read data loaded after write commit).
- Back-to-back: ACCESS -> SETUP with no IDLE gap supported at full rate.
- Counters and proto_err update on the same edge as the event.

## Test plan
- Reset then write 0xDEADBEEF to Paddr 0x0000_0008, read it back -> Prdata = 0xDEADBEEF during read ACCESS, wr_count 1, rd_count 1, proto_err 0.
- Back-to-back write 0x1 to 0x4 then read 0x4 with no IDLE -> read returns 0x1; Prdata 0 in all non-read-ACCESS cycles.
- Paddr 0x0000_0044 with ADDR_BITS 4 -> aliases index 1; read of 0x4 returns same word.
- Penable high in IDLE with own Pselx bit set; separately Paddr change between SETUP and ACCESS -> proto_err 1, no memory write, counters unchanged, stays 1 until reset.
- Pselx = 4'b0011 with SLAVE_ID 0 -> no transfer, proto_err 1; Pselx selecting another slave -> slave idle, Prdata 0, no error.
- Hresetn low during ACCESS of a write -> target word unchanged, counters 0; 0x10000 writes -> wr_count wraps to 0.
